// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default line rates, and the sample-clock divider helper.
package uart_pkg;

    localparam int DEFAULT_BAUD         = 9600;
    localparam int DEFAULT_SAMP_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE_WAIT = 3'd0,
        ARMED     = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        PARITY    = 3'd4,
        STOP      = 3'd5
    } uart_state_t;

    function automatic int clk_per_samp(input int clk_hz, input int baud, input int spb);
        return clk_hz / (baud * spb);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-rate divider: one-cycle o_samp_tick every CLK_PER_SAMP clocks, held at phase 0 while i_clr is high.
module uart_baud_tick #(
    parameter int CLK_PER_SAMP = 10
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_samp_tick
);
    localparam int CW = (CLK_PER_SAMP > 1) ? $clog2(CLK_PER_SAMP) : 1;
    localparam logic [CW-1:0] CNT_END = CW'(CLK_PER_SAMP - 1);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap      = (r_cnt == CNT_END);
    assign o_samp_tick = w_wrap & ~i_clr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with 3-sample majority vote, false-start rejection and framing check; no backpressure.
// valid_out pulses one clock after the stop-bit decision; the parity stage exists only with UART_RX_PARITY_EN.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 65_000_000,
    parameter int BAUD_RATE    = DEFAULT_BAUD,
    parameter int SAMP_PER_BIT = DEFAULT_SAMP_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int IDLE_CYCLES  = 65_000,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 sig_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 busy_out,
    output logic                 frame_err_out,
    output logic                 parity_err_out
);
    localparam int CPS = clk_per_samp(CLK_HZ, BAUD_RATE, SAMP_PER_BIT);
    localparam int SW  = $clog2(SAMP_PER_BIT);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam int IW  = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;

    localparam logic [SW-1:0] IDX_V0   = SW'(SAMP_PER_BIT / 2 - 1);
    localparam logic [SW-1:0] IDX_V1   = SW'(SAMP_PER_BIT / 2);
    localparam logic [SW-1:0] IDX_DEC  = SW'(SAMP_PER_BIT / 2 + 1);
    localparam logic [SW-1:0] IDX_END  = SW'(SAMP_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [IW-1:0] IDLE_END = IW'(IDLE_CYCLES - 1);

    uart_state_t          r_state;
    uart_state_t          w_state_nxt;

    logic                 r_meta;
    logic                 r_sync;
    logic                 r_prev;
    logic [SW-1:0]        r_samp_idx;
    logic                 r_v0;
    logic                 r_v1;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [IW-1:0]        r_idle_cnt;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_perr;

    logic                 w_tick;
    logic                 w_in_frame;
    logic                 w_baud_clr;
    logic                 w_decide;
    logic                 w_vote;
    logic                 w_fall;
    logic                 w_idle_done;
    logic                 w_par_err;
    logic                 w_load;
    logic                 w_ferr_set;
    logic                 w_perr_set;

    assign w_in_frame  = (r_state == START) || (r_state == DATA) ||
                         (r_state == PARITY) || (r_state == STOP);
    assign w_baud_clr  = ~w_in_frame;
    assign w_decide    = w_in_frame && w_tick && (r_samp_idx == IDX_DEC);
    assign w_vote      = (r_v0 & r_v1) | (r_v0 & r_sync) | (r_v1 & r_sync);
    assign w_fall      = r_prev & ~r_sync;
    assign w_idle_done = r_sync && (r_idle_cnt == IDLE_END);

    uart_baud_tick #(
        .CLK_PER_SAMP(CPS)
    ) u_baud_tick (
        .i_clk      (clk_in),
        .i_rst      (rst_in),
        .i_clr      (w_baud_clr),
        .o_samp_tick(w_tick)
    );

`ifdef UART_RX_PARITY_EN
    logic r_par;

    assign w_par_err = r_par != ((^r_shift) ^ PARITY_ODD);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_par <= 1'b0;
        end else if (r_state == PARITY && w_decide) begin
            r_par <= w_vote;
        end
    end
`else
    logic w_unused_parity_odd;

    assign w_par_err           = 1'b0;
    assign w_unused_parity_odd = PARITY_ODD;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= IDLE_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_ferr_set  = 1'b0;
        w_perr_set  = 1'b0;
        case (r_state)
            IDLE_WAIT: if (w_idle_done) w_state_nxt = ARMED;
            ARMED:     if (w_fall) w_state_nxt = START;
            START:     if (w_decide) w_state_nxt = w_vote ? ARMED : DATA;
            DATA: begin
                if (w_decide && r_bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = PARITY;
`else
                    w_state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY:    if (w_decide) w_state_nxt = STOP;
`endif
            STOP: begin
                if (w_decide) begin
                    w_load      = w_vote & ~w_par_err;
                    w_ferr_set  = ~w_vote;
                    w_perr_set  = w_par_err;
                    // A bad stop bit means we may be mid-stream: re-qualify the line before re-arming.
                    w_state_nxt = w_vote ? ARMED : IDLE_WAIT;
                end
            end
            default:   w_state_nxt = IDLE_WAIT;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_meta     <= 1'b1;
            r_sync     <= 1'b1;
            r_prev     <= 1'b1;
            r_samp_idx <= '0;
            r_v0       <= 1'b0;
            r_v1       <= 1'b0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_idle_cnt <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
            r_perr     <= 1'b0;
        end else begin
            r_meta <= sig_in;
            r_sync <= r_meta;
            r_prev <= r_sync;

            if (!w_in_frame) begin
                r_samp_idx <= '0;
            end else if (w_tick) begin
                r_samp_idx <= (r_samp_idx == IDX_END) ? '0 : r_samp_idx + 1'b1;
            end

            if (w_tick && r_samp_idx == IDX_V0) r_v0 <= r_sync;
            if (w_tick && r_samp_idx == IDX_V1) r_v1 <= r_sync;

            // LSB arrives first, so shifting in at the MSB leaves the word aligned after the last bit.
            if (r_state == START) begin
                r_bit_cnt <= '0;
            end else if (r_state == DATA && w_decide) begin
                r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if (r_state != IDLE_WAIT || !r_sync) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != IDLE_END) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end

            if (w_load) r_data <= r_shift;
            r_valid <= w_load;
            r_ferr  <= w_ferr_set;
            r_perr  <= w_perr_set;
        end
    end

    assign data_out       = r_data;
    assign valid_out      = r_valid;
    assign busy_out       = w_in_frame;
    assign frame_err_out  = r_ferr;
    assign parity_err_out = r_perr;

endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
module tb_uart_rx_param;
    localparam int  CLK_HZ = 1_600_000;
    localparam int  BAUD   = 10_000;
    localparam int  SPB    = 16;
    localparam int  IDLE   = 200;
    localparam int  DB     = 8;
    localparam int  CPB    = 160;
    localparam bit  ODD    = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam int  PAR_BITS = 1;
`else
    localparam int  PAR_BITS = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sig = 1'b1;
    logic [DB-1:0] data_out;
    logic          valid_out;
    logic          busy_out;
    logic          frame_err_out;
    logic          parity_err_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // kind = {valid, frame_err, parity_err}; stop_cyc = cycle the stop bit began on the line
    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         stop_cyc;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] model_data = 8'h00;
    logic [7:0] last_seen  = 8'h00;
    logic [2:0] k_now;
    ev_t        ev_now;
    int         dt;

    uart_rx_param #(
        .CLK_HZ      (CLK_HZ),
        .BAUD_RATE   (BAUD),
        .SAMP_PER_BIT(SPB),
        .DATA_BITS   (DB),
        .IDLE_CYCLES (IDLE),
        .PARITY_ODD  (ODD)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .sig_in        (sig),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .busy_out      (busy_out),
        .frame_err_out (frame_err_out),
        .parity_err_out(parity_err_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic exp_parity(input logic [7:0] d);
        return (^d) ^ ODD;
    endfunction

    // Line bits in transmit order: index 0 is the start bit.
    function automatic logic [11:0] frame_word(input logic [7:0] d, input logic stop_v, input logic par_v);
        logic [11:0] w;
        if (PAR_BITS == 1) w = {1'b0, stop_v, par_v, d, 1'b0};
        else               w = {2'b00, stop_v, d, 1'b0};
        return w;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 sig = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic stop_v, input logic par_v,
                        input bit armed, input logic [11:0] gmask, input int goff);
        logic [11:0] w;
        int          n;
        logic        perr;
        ev_t         e;
        w    = frame_word(d, stop_v, par_v);
        n    = 2 + DB + PAR_BITS;
        perr = (PAR_BITS == 1) && (par_v != exp_parity(d));
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < CPB; c++) begin
                @(posedge clk);
                #1 sig = w[i] ^ (gmask[i] && c >= goff && c < goff + 10);
                if (i == n - 1 && c == 0 && armed) begin
                    e.kind     = {stop_v && !perr, !stop_v, perr};
                    e.data     = d;
                    e.stop_cyc = cyc;
                    exp_q.push_back(e);
                end
                if (i == 4 && c == 80) check("busy_mid_frame", busy_out, armed);
            end
        end
    endtask

    // Single compare process: every strobe must match the next expected frame outcome,
    // arrive one clock after the stop-bit decision point, and data_out may only move with valid.
    always @(negedge clk) begin
        if (!rst) begin
            k_now = {valid_out, frame_err_out, parity_err_out};
            if (k_now != 3'b000) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe: got kind %b at cycle %0d, expected none", k_now, cyc);
                end else begin
                    ev_now = exp_q.pop_front();
                    check("strobe_kind", k_now, ev_now.kind);
                    dt = cyc - ev_now.stop_cyc;
                    checks++;
                    if (dt < 95 || dt > 112) begin
                        failures++;
                        $display("FAIL strobe_time: got %0d cycles after stop edge, expected 95..112", dt);
                    end
                    if (ev_now.kind[2]) model_data = ev_now.data;
                end
            end
            if (k_now != 3'b000 || data_out !== last_seen) check("data_out", data_out, model_data);
        end
        last_seen = data_out;
    end

    initial begin
        logic [11:0] w;
        logic [7:0]  d;
        int          gap;
        int          gb;

        #1;
        check("rst_data", data_out, 8'h00);
        check("rst_valid", valid_out, 1'b0);
        check("rst_busy", busy_out, 1'b0);
        check("rst_ferr", frame_err_out, 1'b0);
        check("rst_perr", parity_err_out, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        idle(210);
        send(8'hA5, 1'b1, exp_parity(8'hA5), 1'b1, 12'h000, 0);
        idle(20);
        check("lit_A5", data_out, 8'hA5);

        send(8'h00, 1'b1, exp_parity(8'h00), 1'b1, 12'h000, 0);
        send(8'hFF, 1'b1, exp_parity(8'hFF), 1'b1, 12'h000, 0);
        send(8'h3C, 1'b1, exp_parity(8'h3C), 1'b1, 12'h000, 0);
        idle(20);
        check("lit_3C", data_out, 8'h3C);

        idle(100);
        for (int t = 0; t < 50; t++) begin
            @(posedge clk);
            #1 sig = 1'b0;
            if (t == 40) check("false_start_busy", busy_out, 1'b1);
        end
        idle(150);
        check("false_start_idle", busy_out, 1'b0);
        send(8'h5A, 1'b1, exp_parity(8'h5A), 1'b1, 12'h000, 0);
        idle(20);
        check("lit_5A", data_out, 8'h5A);

        send(8'h81, 1'b0, exp_parity(8'h81), 1'b1, 12'h000, 0);
        idle(50);
        send(8'h55, 1'b1, exp_parity(8'h55), 1'b0, 12'h000, 0);
        idle(250);
        send(8'h42, 1'b1, exp_parity(8'h42), 1'b1, 12'h000, 0);
        idle(20);
        check("lit_42", data_out, 8'h42);

        send(8'h55, 1'b1, exp_parity(8'h55), 1'b1, 12'h1FE, 75);
        idle(20);
        check("lit_55_glitch", data_out, 8'h55);

        for (int f = 0; f < 6; f++) begin
            d   = 8'($urandom_range(0, 255));
            gap = $urandom_range(0, 300);
            gb  = $urandom_range(0, 9);
            idle(gap);
            w = 12'h000;
            if (gb >= 1 && gb <= 8) w[gb] = 1'b1;
            send(d, 1'b1, exp_parity(d), 1'b1, w, $urandom_range(0, 150));
        end

        idle(40);
        w = frame_word(8'hC3, 1'b1, exp_parity(8'hC3));
        for (int t = 0; t < 4 * CPB + 80; t++) begin
            @(posedge clk);
            #1 sig = w[t / CPB];
        end
        check("busy_before_rst", busy_out, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_data", data_out, 8'h00);
        check("midrst_valid", valid_out, 1'b0);
        check("midrst_busy", busy_out, 1'b0);
        check("midrst_ferr", frame_err_out, 1'b0);
        check("midrst_perr", parity_err_out, 1'b0);
        model_data = 8'h00;
        sig = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(210);
        send(8'h96, 1'b1, exp_parity(8'h96), 1'b1, 12'h000, 0);
        idle(20);
        check("lit_96", data_out, 8'h96);

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b1, 1'b1, 12'h000, 0);
        send(8'h06, 1'b1, 1'b1, 1'b1, 12'h000, 0);
        send(8'h07, 1'b1, 1'b0, 1'b1, 12'h000, 0);
        idle(20);
        check("lit_07_kept", data_out, 8'h07);
        send(8'h07, 1'b0, 1'b0, 1'b1, 12'h000, 0);
        idle(210);
        send(8'h18, 1'b1, exp_parity(8'h18), 1'b1, 12'h000, 0);
        idle(20);
        check("lit_18", data_out, 8'h18);
`endif

        idle(50);
        check("pending_events", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
